// File: rtl/data_types_pkg.sv
// Shared datapath types for the reservation stations and the common data bus.
// The CDB arbiter adds only its source count here.
package data_types;

   typedef logic [31:0] word32_t;

   typedef enum logic [2:0] {
      NO_VAL = 3'd0,
      ALU_1  = 3'd1,
      ALU_2  = 3'd2,
      ALU_3  = 3'd3,
      MUL_1  = 3'd4,
      MUL_2  = 3'd5,
      LD_1   = 3'd6,
      LD_2   = 3'd7
   } rs_tag_t;

   typedef struct packed {
      rs_tag_t tag;
      word32_t val;
   } cdb_t;

   localparam int NUM_CDB_SRC = 4;

endpackage

// File: rtl/cdb_arbiter_slot.sv
// One-entry result holding register for a single functional unit.
// The slot frees itself when granted and may refill on that same edge.
module cdb_slot
   import data_types::*;
(
   input  logic    clk_i,
   input  logic    reset_i,
   input  logic    i_valid,
   input  rs_tag_t i_tag,
   input  word32_t i_val,
   input  logic    i_grant,
   output logic    o_ready,
   output logic    o_held,
   output cdb_t    o_data
);

   logic r_held;
   cdb_t r_data;
   logic w_accept;

   assign o_ready  = !r_held | i_grant;
   assign w_accept = i_valid & o_ready & (i_tag != NO_VAL);
   assign o_held   = r_held;
   assign o_data   = r_data;

   // A new accept wins over a grant so a lone source streams one result per cycle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_held <= 1'b0;
         r_data <= '{tag: NO_VAL, val: 32'd0};
      end else if (w_accept) begin
         r_held <= 1'b1;
         r_data <= '{tag: i_tag, val: i_val};
      end else if (i_grant) begin
         r_held <= 1'b0;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers one finished result per functional unit and broadcasts at most one
// per cycle on the common data bus, chosen round-robin among held slots.
module cdb_arbiter
   import data_types::*;
#(
   parameter int NUM_SRC = NUM_CDB_SRC
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [NUM_SRC-1:0] src_valid_i,
   input  rs_tag_t            src_tag_i [NUM_SRC],
   input  word32_t            src_val_i [NUM_SRC],
   output logic [NUM_SRC-1:0] src_ready_o,
   output cdb_t               cdb_o,
   output logic [NUM_SRC-1:0] cdb_grant_o
);

   localparam int IDX_W = $clog2(NUM_SRC);

   logic [IDX_W-1:0]   r_rr_ptr;
   logic [NUM_SRC-1:0] w_held;
   logic [NUM_SRC-1:0] w_grant;
   logic [IDX_W-1:0]   w_gnt_idx;
   logic               w_found;
   int                 w_cand;
   cdb_t               w_slot_data [NUM_SRC];

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_slot
         cdb_slot u_slot (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .i_valid (src_valid_i[g]),
            .i_tag   (src_tag_i[g]),
            .i_val   (src_val_i[g]),
            .i_grant (w_grant[g]),
            .o_ready (src_ready_o[g]),
            .o_held  (w_held[g]),
            .o_data  (w_slot_data[g])
         );
      end
   endgenerate

   // Search starts one past the last winner so every held slot wins within NUM_SRC cycles.
   always_comb begin
      w_grant   = '0;
      w_gnt_idx = '0;
      w_found   = 1'b0;
      w_cand    = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         w_cand = (int'(r_rr_ptr) + k) % NUM_SRC;
         if (!w_found && w_held[IDX_W'(w_cand)]) begin
            w_found   = 1'b1;
            w_gnt_idx = IDX_W'(w_cand);
         end
      end
      if (w_found) begin
         w_grant[w_gnt_idx] = 1'b1;
      end
   end

   // Bus mux: idle bus carries NO_VAL with a zero value.
   always_comb begin
      cdb_o = '{tag: NO_VAL, val: 32'd0};
      if (w_found) begin
         cdb_o = w_slot_data[w_gnt_idx];
      end
   end

   assign cdb_grant_o = w_grant;

   // Pointer reset to the last index makes source 0 the first winner.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_rr_ptr <= IDX_W'(NUM_SRC - 1);
      end else if (w_found) begin
         r_rr_ptr <= w_gnt_idx;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: table vectors, directed corner cases,
// and random traffic against a per-source pending-result model.
module tb_cdb_arbiter;
   import data_types::*;

   localparam int N = 4;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic [N-1:0]  src_valid_i;
   rs_tag_t       src_tag_i [N];
   word32_t       src_val_i [N];
   logic [N-1:0]  src_ready_o;
   cdb_t          cdb_o;
   logic [N-1:0]  cdb_grant_o;

   int n_cmp = 0;
   int n_err = 0;

   // model: one pending result per source plus the index of the last winner
   bit       m_held [N];
   rs_tag_t  m_tag  [N];
   word32_t  m_val  [N];
   int       m_last;
   int       e_win;
   logic [N-1:0] e_ready;

   rs_tag_t SRC_TAG [N];

   typedef struct {
      logic [N-1:0] valid;
      bit           tag0_none;
      logic [N-1:0] exp_ready;
      logic [N-1:0] exp_grant;
      rs_tag_t      exp_tag;
      word32_t      exp_val;
   } vec_t;
   vec_t vecs [8];

   cdb_arbiter #(.NUM_SRC(N)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .src_valid_i (src_valid_i),
      .src_tag_i   (src_tag_i),
      .src_val_i   (src_val_i),
      .src_ready_o (src_ready_o),
      .cdb_o       (cdb_o),
      .cdb_grant_o (cdb_grant_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_held[i] = 1'b0;
         m_tag[i]  = NO_VAL;
         m_val[i]  = 32'd0;
      end
      m_last = N - 1;
   endtask

   // check outputs mid-cycle against the model, then advance model on the edge
   task automatic tick();
      logic [N-1:0] eg;
      cdb_t ec;
      @(negedge clk_i);
      e_win = -1;
      for (int k = 1; k <= N; k++) begin
         if (e_win < 0 && m_held[(m_last + k) % N]) e_win = (m_last + k) % N;
      end
      eg = '0;
      ec = '{tag: NO_VAL, val: 32'd0};
      if (e_win >= 0) begin
         eg[e_win] = 1'b1;
         ec = '{tag: m_tag[e_win], val: m_val[e_win]};
      end
      for (int i = 0; i < N; i++) e_ready[i] = !m_held[i] || (e_win == i);
      chk("model_ready", 64'(src_ready_o), 64'(e_ready));
      chk("model_grant", 64'(cdb_grant_o), 64'(eg));
      chk("model_cdb",   64'(cdb_o),       64'(ec));
      @(posedge clk_i);
      for (int i = 0; i < N; i++) begin
         if (src_valid_i[i] && e_ready[i] && src_tag_i[i] != NO_VAL) begin
            m_held[i] = 1'b1;
            m_tag[i]  = src_tag_i[i];
            m_val[i]  = src_val_i[i];
         end else if (e_win == i) begin
            m_held[i] = 1'b0;
         end
      end
      if (e_win >= 0) m_last = e_win;
      #1;
   endtask

   task automatic idle_inputs();
      src_valid_i = '0;
      for (int i = 0; i < N; i++) begin
         src_tag_i[i] = NO_VAL;
         src_val_i[i] = 32'd0;
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_i = 1'b1;
      model_reset();
      #1;
      chk("rst_tag",   64'(cdb_o.tag),   64'(NO_VAL));
      chk("rst_val",   64'(cdb_o.val),   64'd0);
      chk("rst_grant", 64'(cdb_grant_o), 64'd0);
      chk("rst_ready", 64'(src_ready_o), 64'hF);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
   endtask

   task automatic drive_src(input int i, input rs_tag_t t, input word32_t v);
      src_valid_i[i] = 1'b1;
      src_tag_i[i]   = t;
      src_val_i[i]   = v;
   endtask

   initial begin
      SRC_TAG[0] = ALU_1; SRC_TAG[1] = ALU_2; SRC_TAG[2] = MUL_1; SRC_TAG[3] = LD_1;
      // load all four, drain in order 0..3, then a NO_VAL-tagged valid stores nothing
      vecs[0] = '{4'b1111, 1'b0, 4'b1111, 4'b0000, NO_VAL, 32'd0};
      vecs[1] = '{4'b0000, 1'b0, 4'b0001, 4'b0001, ALU_1,  32'd10};
      vecs[2] = '{4'b0000, 1'b0, 4'b0011, 4'b0010, ALU_2,  32'd20};
      vecs[3] = '{4'b0000, 1'b0, 4'b0111, 4'b0100, MUL_1,  32'd30};
      vecs[4] = '{4'b0000, 1'b0, 4'b1111, 4'b1000, LD_1,   32'd40};
      vecs[5] = '{4'b0001, 1'b1, 4'b1111, 4'b0000, NO_VAL, 32'd0};
      vecs[6] = '{4'b0000, 1'b0, 4'b1111, 4'b0000, NO_VAL, 32'd0};
      vecs[7] = '{4'b0000, 1'b0, 4'b1111, 4'b0000, NO_VAL, 32'd0};

      do_reset();

      // table vectors
      for (int r = 0; r < 8; r++) begin
         idle_inputs();
         for (int i = 0; i < N; i++) begin
            if (vecs[r].valid[i]) drive_src(i, SRC_TAG[i], 32'(10 * (i + 1)));
         end
         if (vecs[r].tag0_none) src_tag_i[0] = NO_VAL;
         #1;
         chk("vec_ready", 64'(src_ready_o), 64'(vecs[r].exp_ready));
         chk("vec_grant", 64'(cdb_grant_o), 64'(vecs[r].exp_grant));
         chk("vec_tag",   64'(cdb_o.tag),   64'(vecs[r].exp_tag));
         chk("vec_val",   64'(cdb_o.val),   64'(vecs[r].exp_val));
         tick();
      end

      // async reset mid-cycle with slots 1 and 2 held
      do_reset();
      idle_inputs();
      drive_src(1, ALU_2, 32'd111);
      drive_src(2, MUL_1, 32'd222);
      tick();
      idle_inputs();
      chk("pre_rst_grant", 64'(cdb_grant_o), 64'b0010);
      #2;
      reset_i = 1'b1;
      model_reset();
      #1;
      chk("midrst_tag",   64'(cdb_o.tag),   64'(NO_VAL));
      chk("midrst_grant", 64'(cdb_grant_o), 64'd0);
      chk("midrst_ready", 64'(src_ready_o), 64'hF);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      for (int k = 0; k < 4; k++) tick();

      // lone source 2 streaming one result per cycle
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         idle_inputs();
         drive_src(2, ALU_1, 32'(k));
         tick();
         chk("stream_tag",   64'(cdb_o.tag),      64'(ALU_1));
         chk("stream_val",   64'(cdb_o.val),      64'(k));
         chk("stream_ready", 64'(src_ready_o[2]), 64'd1);
      end
      idle_inputs();
      tick();
      tick();

      // sources 1 and 3 continuously: grants alternate 1,3,1,3
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         idle_inputs();
         drive_src(1, ALU_2, 32'(100 + k));
         drive_src(3, LD_1,  32'(300 + k));
         tick();
         chk("alt_grant", 64'(cdb_grant_o), (k % 2 == 1) ? 64'b0010 : 64'b1000);
      end
      idle_inputs();
      for (int k = 0; k < 3; k++) tick();

      // held slot 0 is not overwritten while FU 0 is backpressured
      do_reset();
      idle_inputs();
      drive_src(0, ALU_1, 32'd1);
      tick();
      idle_inputs();
      drive_src(0, ALU_1, 32'd2);
      drive_src(1, ALU_2, 32'd3);
      drive_src(2, MUL_1, 32'd4);
      tick();
      idle_inputs();
      drive_src(0, ALU_3, 32'hDEAD);
      chk("bp_ready0_c", 64'(src_ready_o[0]), 64'd0);
      chk("bp_grant_c",  64'(cdb_grant_o),    64'b0010);
      tick();
      chk("bp_ready0_d", 64'(src_ready_o[0]), 64'd0);
      chk("bp_val_d",    64'(cdb_o.val),      64'd4);
      tick();
      chk("bp_grant_e",  64'(cdb_grant_o),    64'b0001);
      chk("bp_val_e",    64'(cdb_o.val),      64'd2);
      chk("bp_ready0_e", 64'(src_ready_o[0]), 64'd1);
      tick();
      idle_inputs();
      chk("dead_tag", 64'(cdb_o.tag), 64'(ALU_3));
      chk("dead_val", 64'(cdb_o.val), 64'hDEAD);
      tick();
      tick();

      // random traffic; FUs mostly honour backpressure by holding their result
      do_reset();
      idle_inputs();
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!src_valid_i[i] || src_ready_o[i] || $urandom_range(0, 7) == 0) begin
               src_valid_i[i] = ($urandom_range(0, 2) != 0);
               src_tag_i[i]   = rs_tag_t'($urandom_range(0, 7));
               src_val_i[i]   = $urandom;
            end
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
